pmem_arbiter: RTL and testbench

Shares the single 64-bit burst physical-memory port between the instruction cache and the data cache. It accepts whole-line requests (256-bit) from each cache and grants one requester at a time. It sequences a 4-beat burst on the pmem port and returns the assembled line, or drains the write line, to the granted cache. It sits inside the cache top, between the two cache miss interfaces and the external pmem bus.

---
 rtl/pmem_arbiter_pkg.sv | 26 ++
 rtl/pmem_arbiter_if.sv | 21 ++
 rtl/pmem_arbiter_burst_engine.sv | 70 +++++++
 rtl/pmem_arbiter.sv | 119 +++++++++++
 tb/tb_pmem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared cache types for the pmem arbiter: FSM/grant enums, burst geometry, address helper.
// Optional build macro used elsewhere in this slice: PMEM_ARB_ROUND_ROBIN_EN.
package cache_types;

    localparam int PMEM_BEAT_WIDTH = 64;
    localparam int PMEM_BEATS      = 4;
    localparam int LINE_WIDTH      = PMEM_BEAT_WIDTH * PMEM_BEATS;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } arb_req_t;

    // Clears the byte-offset bits so bursts always start on a line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr, input int line_bytes);
        return addr & ~(32'(line_bytes) - 32'd1);
    endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Burst physical-memory bus: the arbiter drives it through master, the memory through slave.
interface pmem_arbiter_if #(
    parameter int BEAT_WIDTH = 64
);
    logic [31:0]           pmem_address;
    logic [BEAT_WIDTH-1:0] pmem_rdata;
    logic [BEAT_WIDTH-1:0] pmem_wdata;
    logic                  pmem_read;
    logic                  pmem_write;
    logic                  pmem_resp;

    modport master (
        output pmem_address, pmem_wdata, pmem_read, pmem_write,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_address, pmem_wdata, pmem_read, pmem_write,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/pmem_arbiter_burst_engine.sv
// Burst engine for pmem_arbiter: beat counter, line pack/unpack and pmem bus drive.
// Behaviour is the same with or without PMEM_ARB_ROUND_ROBIN_EN.
module pmem_burst_engine
    import cache_types::*;
#(
    parameter int BEAT_WIDTH = PMEM_BEAT_WIDTH,
    parameter int BEATS      = PMEM_BEATS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  arb_state_t                    state,
    input  logic                          start,
    input  logic [31:0]                   start_address,
    input  logic [BEAT_WIDTH*BEATS-1:0]   start_wdata,
    output logic                          last_beat,
    output logic [BEAT_WIDTH*BEATS-1:0]   rd_line,
    pmem_arbiter_if.master                pmem
);
    localparam int LINE_W = BEAT_WIDTH * BEATS;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]  beat_cnt;
    logic [31:0]       address_q;
    logic [LINE_W-1:0] wline_q;
    logic [LINE_W-1:0] rline_q;
    logic              busy;
    logic              beat_done;

    assign busy      = (state == RD_BURST) || (state == WR_BURST);
    assign beat_done = busy && pmem.pmem_resp;
    assign last_beat = beat_done && (beat_cnt == LAST_CNT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            address_q <= '0;
        end else if (start) begin
            beat_cnt  <= '0;
            address_q <= line_align(start_address, LINE_W / 8);
        end else if (beat_done) begin
            beat_cnt  <= beat_cnt + 1'b1;
        end
    end

    // NOTE: the line buffers are pure datapath qualified by state, so they carry no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            wline_q <= start_wdata;
        end
        if (state == RD_BURST && pmem.pmem_resp) begin
            rline_q[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= pmem.pmem_rdata;
        end
    end

    // The assembled line includes the beat arriving this cycle, so it is complete on last_beat.
    // NOTE: rd_line takes a full default before the partial overwrite, so no latch is inferred.
    always_comb begin
        rd_line = rline_q;
        rd_line[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH] = pmem.pmem_rdata;
    end

    assign pmem.pmem_read    = (state == RD_BURST);
    assign pmem.pmem_write   = (state == WR_BURST);
    assign pmem.pmem_address = address_q;
    assign pmem.pmem_wdata   = (state == WR_BURST) ? wline_q[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH]
                                                   : '0;

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one burst pmem port.
// PMEM_ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests; otherwise D-cache wins.
module pmem_arbiter
    import cache_types::*;
#(
    parameter int BEAT_WIDTH = PMEM_BEAT_WIDTH,
    parameter int BEATS      = PMEM_BEATS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 i_line_address,
    input  logic                        i_line_read,
    output logic [BEAT_WIDTH*BEATS-1:0] i_line_rdata,
    output logic                        i_line_resp,
    input  logic [31:0]                 d_line_address,
    input  logic                        d_line_read,
    input  logic                        d_line_write,
    input  logic [BEAT_WIDTH*BEATS-1:0] d_line_wdata,
    output logic [BEAT_WIDTH*BEATS-1:0] d_line_rdata,
    output logic                        d_line_resp,
    pmem_arbiter_if.master              pmem
);
    arb_state_t state_q, state_next;
    arb_req_t   grant_q, grant_next;
    logic       i_req, d_req, start, last_beat;
    logic [31:0] start_address;
    logic [BEAT_WIDTH*BEATS-1:0] rd_line;

    assign i_req         = i_line_read;
    assign d_req         = d_line_read | d_line_write;
    assign start         = (state_q == IDLE) && (i_req || d_req);
    assign start_address = (grant_next == REQ_I) ? i_line_address : d_line_address;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    // Points at the requester to favour next: the one not granted most recently.
    arb_req_t rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= REQ_I;
        end else if (start) begin
            rr_ptr <= (grant_next == REQ_I) ? REQ_D : REQ_I;
        end
    end
`endif

    always_comb begin
        grant_next = REQ_D;
        if (i_req && d_req) begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            grant_next = rr_ptr;
`else
            grant_next = REQ_D;
`endif
        end else if (i_req) begin
            grant_next = REQ_I;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= REQ_I;
        end else begin
            state_q <= state_next;
            if (start) begin
                grant_q <= grant_next;
            end
        end
    end

    // A D-cache write outranks a simultaneous D-cache read.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:     if (start) state_next = (grant_next == REQ_D && d_line_write) ? WR_BURST
                                                                                    : RD_BURST;
            RD_BURST: if (last_beat) state_next = DONE;
            WR_BURST: if (last_beat) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        i_line_resp = (state_q == DONE) && (grant_q == REQ_I);
        d_line_resp = (state_q == DONE) && (grant_q == REQ_D);
    end

    // Returned lines persist until the same requester's next read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_line_rdata <= '0;
            d_line_rdata <= '0;
        end else if (last_beat && state_q == RD_BURST) begin
            if (grant_q == REQ_I) begin
                i_line_rdata <= rd_line;
            end else begin
                d_line_rdata <= rd_line;
            end
        end
    end

    pmem_burst_engine #(
        .BEAT_WIDTH (BEAT_WIDTH),
        .BEATS      (BEATS)
    ) u_burst_engine (
        .clk           (clk),
        .rst           (rst),
        .state         (state_q),
        .start         (start),
        .start_address (start_address),
        .start_wdata   (d_line_wdata),
        .last_beat     (last_beat),
        .rd_line       (rd_line),
        .pmem          (pmem)
    );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter: reads, writes, arbitration, reset, throughput.
// Arbitration expectations follow PMEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_line_address;
    logic         i_line_read;
    logic [255:0] i_line_rdata;
    logic         i_line_resp;
    logic [31:0]  d_line_address;
    logic         d_line_read;
    logic         d_line_write;
    logic [255:0] d_line_wdata;
    logic [255:0] d_line_rdata;
    logic         d_line_resp;

    int checks = 0;
    int passed = 0;
    bit rr_pref_i;   // model of the round-robin pointer: 1 = I-cache favoured

    pmem_arbiter_if pmem_bus ();

    pmem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_line_address (i_line_address),
        .i_line_read    (i_line_read),
        .i_line_rdata   (i_line_rdata),
        .i_line_resp    (i_line_resp),
        .d_line_address (d_line_address),
        .d_line_read    (d_line_read),
        .d_line_write   (d_line_write),
        .d_line_wdata   (d_line_wdata),
        .d_line_rdata   (d_line_rdata),
        .d_line_resp    (d_line_resp),
        .pmem           (pmem_bus.master)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_W = {64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
                                       64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};
    localparam logic [255:0] LINE_B = {64'h0807_0605_0403_0201, 64'h1817_1615_1413_1211,
                                       64'h2827_2625_2423_2221, 64'h3837_3635_3433_3231};
    localparam logic [255:0] LINE_C = {64'hC3C3_0000_0000_0003, 64'hC2C2_0000_0000_0002,
                                       64'hC1C1_0000_0000_0001, 64'hC0C0_0000_0000_0000};
    localparam logic [255:0] LINE_D = {64'hD3D3_1111_0000_0003, 64'hD2D2_1111_0000_0002,
                                       64'hD1D1_1111_0000_0001, 64'hD0D0_1111_0000_0000};
    localparam logic [255:0] LINE_E = {64'hE3E3_2222_0000_0003, 64'hE2E2_2222_0000_0002,
                                       64'hE1E1_2222_0000_0001, 64'hE0E0_2222_0000_0000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays memory for one burst already accepted by the DUT; returns what it observed.
    // Leaves the bench #1 after the edge that took the last beat (DUT in DONE).
    task automatic serve_burst(input logic [255:0] rline, input int gap,
                               output logic [255:0] seen_wdata, output logic seen_rd,
                               output logic seen_wr, output logic seen_resp);
        seen_wdata = '0;
        seen_rd    = 1'b1;
        seen_wr    = 1'b1;
        seen_resp  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                pmem_bus.pmem_resp = 1'b0;
                seen_resp = seen_resp | i_line_resp | d_line_resp;
                tick();
            end
            pmem_bus.pmem_resp  = 1'b1;
            pmem_bus.pmem_rdata = rline[k*64 +: 64];
            seen_wdata[k*64 +: 64] = pmem_bus.pmem_wdata;
            seen_rd   = seen_rd & pmem_bus.pmem_read;
            seen_wr   = seen_wr & pmem_bus.pmem_write;
            seen_resp = seen_resp | i_line_resp | d_line_resp;
            tick();
        end
        pmem_bus.pmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_line_address = '0; i_line_read = 1'b0;
        d_line_address = '0; d_line_read = 1'b0; d_line_write = 1'b0; d_line_wdata = '0;
        pmem_bus.pmem_resp = 1'b0; pmem_bus.pmem_rdata = '0;
        tick();
        tick();
        checks++; if ({pmem_bus.pmem_read, pmem_bus.pmem_write} !== 2'b00)
            $display("FAIL reset_rw: got %b expected 00", {pmem_bus.pmem_read, pmem_bus.pmem_write});
        else passed++;
        checks++; if (pmem_bus.pmem_address !== 32'h0)
            $display("FAIL reset_address: got %h expected 0", pmem_bus.pmem_address);
        else passed++;
        checks++; if (pmem_bus.pmem_wdata !== 64'h0)
            $display("FAIL reset_wdata: got %h expected 0", pmem_bus.pmem_wdata);
        else passed++;
        checks++; if ({i_line_resp, d_line_resp} !== 2'b00)
            $display("FAIL reset_resp: got %b expected 00", {i_line_resp, d_line_resp});
        else passed++;
        checks++; if (i_line_rdata !== 256'h0 || d_line_rdata !== 256'h0)
            $display("FAIL reset_rdata: got i=%h d=%h expected 0", i_line_rdata, d_line_rdata);
        else passed++;
        rst = 1'b0;
        rr_pref_i = 1'b1;
        tick();
    endtask

    task automatic test_i_read();
        logic [255:0] wd; logic rd, wr, early;
        i_line_address = 32'h0000_0060;
        i_line_read    = 1'b1;
        tick();  // edge N samples the request
        checks++; if ({pmem_bus.pmem_read, pmem_bus.pmem_write} !== 2'b10)
            $display("FAIL iread_start: got rw=%b expected 10", {pmem_bus.pmem_read, pmem_bus.pmem_write});
        else passed++;
        checks++; if (pmem_bus.pmem_address !== 32'h0000_0060)
            $display("FAIL iread_address: got %h expected 00000060", pmem_bus.pmem_address);
        else passed++;
        serve_burst(LINE_A, 0, wd, rd, wr, early);
        checks++; if ({rd, wr, early} !== 3'b100)
            $display("FAIL iread_burst: got rd/wr/early=%b expected 100", {rd, wr, early});
        else passed++;
        checks++; if ({i_line_resp, d_line_resp} !== 2'b10)
            $display("FAIL iread_resp: got i/d=%b expected 10", {i_line_resp, d_line_resp});
        else passed++;
        checks++; if (i_line_rdata !== LINE_A)
            $display("FAIL iread_rdata: got %h expected %h", i_line_rdata, LINE_A);
        else passed++;
        checks++; if (pmem_bus.pmem_read !== 1'b0)
            $display("FAIL iread_drop: got pmem_read=%b expected 0", pmem_bus.pmem_read);
        else passed++;
        i_line_read = 1'b0;
        rr_pref_i = 1'b0;
        tick();
        checks++; if (i_line_resp !== 1'b0 || i_line_rdata !== LINE_A)
            $display("FAIL iread_hold: got resp=%b rdata=%h expected 0 and %h", i_line_resp, i_line_rdata, LINE_A);
        else passed++;
        tick();
    endtask

    task automatic test_d_write();
        logic [255:0] wd; logic rd, wr, early;
        d_line_address = 32'h0000_1000;
        d_line_wdata   = LINE_W;
        d_line_write   = 1'b1;
        tick();
        // Scramble the requester side; the latched burst must not notice.
        d_line_wdata   = '1;
        d_line_address = 32'hFFFF_FFE0;
        checks++; if ({pmem_bus.pmem_read, pmem_bus.pmem_write} !== 2'b01)
            $display("FAIL dwrite_start: got rw=%b expected 01", {pmem_bus.pmem_read, pmem_bus.pmem_write});
        else passed++;
        checks++; if (pmem_bus.pmem_address !== 32'h0000_1000)
            $display("FAIL dwrite_address: got %h expected 00001000", pmem_bus.pmem_address);
        else passed++;
        serve_burst(LINE_E, 2, wd, rd, wr, early);
        checks++; if (wd !== LINE_W)
            $display("FAIL dwrite_beats: got %h expected %h", wd, LINE_W);
        else passed++;
        checks++; if ({rd, wr, early} !== 3'b010)
            $display("FAIL dwrite_burst: got rd/wr/early=%b expected 010", {rd, wr, early});
        else passed++;
        checks++; if ({i_line_resp, d_line_resp} !== 2'b01)
            $display("FAIL dwrite_resp: got i/d=%b expected 01", {i_line_resp, d_line_resp});
        else passed++;
        d_line_write = 1'b0;
        rr_pref_i = 1'b1;
        tick();
        checks++; if (d_line_resp !== 1'b0 || d_line_rdata !== 256'h0)
            $display("FAIL dwrite_after: got resp=%b rdata=%h expected 0 and 0", d_line_resp, d_line_rdata);
        else passed++;
        tick();
    endtask

    task automatic test_unaligned();
        logic [255:0] wd; logic rd, wr, early;
        i_line_address = 32'h0000_0067;
        i_line_read    = 1'b1;
        tick();
        checks++; if (pmem_bus.pmem_address !== 32'h0000_0060)
            $display("FAIL unaligned_address: got %h expected 00000060", pmem_bus.pmem_address);
        else passed++;
        serve_burst(LINE_B, 1, wd, rd, wr, early);
        checks++; if (i_line_resp !== 1'b1 || i_line_rdata !== LINE_B)
            $display("FAIL unaligned_rdata: got resp=%b rdata=%h expected 1 and %h", i_line_resp, i_line_rdata, LINE_B);
        else passed++;
        i_line_read = 1'b0;
        rr_pref_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_simultaneous(input int pass);
        logic [255:0] wd; logic rd, wr, early;
        logic first_i;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        first_i = rr_pref_i;
`else
        first_i = 1'b0;
`endif
        i_line_address = 32'h0000_0200; i_line_read = 1'b1;
        d_line_address = 32'h0000_0400; d_line_read = 1'b1;
        tick();
        checks++; if (pmem_bus.pmem_address !== (first_i ? 32'h0000_0200 : 32'h0000_0400))
            $display("FAIL simul%0d_first_address: got %h expected %h", pass, pmem_bus.pmem_address,
                     first_i ? 32'h0000_0200 : 32'h0000_0400);
        else passed++;
        serve_burst(LINE_C, 0, wd, rd, wr, early);
        checks++; if ({i_line_resp, d_line_resp} !== {first_i, ~first_i})
            $display("FAIL simul%0d_first_resp: got i/d=%b expected %b", pass, {i_line_resp, d_line_resp}, {first_i, ~first_i});
        else passed++;
        checks++; if ((first_i ? i_line_rdata : d_line_rdata) !== LINE_C)
            $display("FAIL simul%0d_first_rdata: got %h expected %h", pass, first_i ? i_line_rdata : d_line_rdata, LINE_C);
        else passed++;
        if (first_i) i_line_read = 1'b0; else d_line_read = 1'b0;
        tick();
        tick();  // IDLE edge picks up the waiting requester
        rr_pref_i = first_i;  // two grants flip the pointer twice
        checks++; if (pmem_bus.pmem_read !== 1'b1 || pmem_bus.pmem_address !== (first_i ? 32'h0000_0400 : 32'h0000_0200))
            $display("FAIL simul%0d_second_start: got read=%b address=%h", pass, pmem_bus.pmem_read, pmem_bus.pmem_address);
        else passed++;
        serve_burst(LINE_D, 0, wd, rd, wr, early);
        checks++; if ({i_line_resp, d_line_resp} !== {~first_i, first_i})
            $display("FAIL simul%0d_second_resp: got i/d=%b expected %b", pass, {i_line_resp, d_line_resp}, {~first_i, first_i});
        else passed++;
        checks++; if ((first_i ? d_line_rdata : i_line_rdata) !== LINE_D || (first_i ? i_line_rdata : d_line_rdata) !== LINE_C)
            $display("FAIL simul%0d_second_rdata: got i=%h d=%h", pass, i_line_rdata, d_line_rdata);
        else passed++;
        i_line_read = 1'b0;
        d_line_read = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        logic [255:0] wd; logic rd, wr, early;
        logic stray;
        i_line_address = 32'h0000_0080;
        i_line_read    = 1'b1;
        tick();
        pmem_bus.pmem_resp = 1'b1;
        pmem_bus.pmem_rdata = 64'h5555_5555_5555_5555;
        tick();
        pmem_bus.pmem_rdata = 64'h6666_6666_6666_6666;
        tick();
        pmem_bus.pmem_resp = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (pmem_bus.pmem_read !== 1'b0 || pmem_bus.pmem_address !== 32'h0)
            $display("FAIL midrst_bus: got read=%b address=%h expected 0 and 0", pmem_bus.pmem_read, pmem_bus.pmem_address);
        else passed++;
        checks++; if (i_line_resp !== 1'b0 || i_line_rdata !== 256'h0)
            $display("FAIL midrst_resp: got resp=%b rdata=%h expected 0 and 0", i_line_resp, i_line_rdata);
        else passed++;
        rst = 1'b0;
        i_line_read = 1'b0;
        rr_pref_i = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            stray = stray | i_line_resp | d_line_resp | pmem_bus.pmem_read;
        end
        checks++; if (stray !== 1'b0)
            $display("FAIL midrst_quiet: got activity=%b expected 0", stray);
        else passed++;
        d_line_address = 32'h0000_0100;
        d_line_read    = 1'b1;
        tick();
        serve_burst(LINE_D, 0, wd, rd, wr, early);
        checks++; if (d_line_resp !== 1'b1 || d_line_rdata !== LINE_D || i_line_rdata !== 256'h0)
            $display("FAIL midrst_recover: got resp=%b d=%h i=%h", d_line_resp, d_line_rdata, i_line_rdata);
        else passed++;
        d_line_read = 1'b0;
        rr_pref_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [255:0] wd; logic rd, wr, early;
        i_line_address = 32'h0000_0040;
        i_line_read    = 1'b1;
        tick();  // edge N
        serve_burst(LINE_A, 0, wd, rd, wr, early);
        checks++; if (i_line_resp !== 1'b1 || i_line_rdata !== LINE_A)
            $display("FAIL b2b_first: got resp=%b rdata=%h", i_line_resp, i_line_rdata);
        else passed++;
        // Junk beats during DONE and IDLE must be ignored.
        pmem_bus.pmem_resp  = 1'b1;
        pmem_bus.pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        checks++; if (pmem_bus.pmem_read !== 1'b0 || i_line_resp !== 1'b0)
            $display("FAIL b2b_idle: got read=%b resp=%b expected 0 and 0", pmem_bus.pmem_read, i_line_resp);
        else passed++;
        tick();  // edge N+6 treats the held request as new
        checks++; if (pmem_bus.pmem_read !== 1'b1)
            $display("FAIL b2b_restart: got read=%b expected 1", pmem_bus.pmem_read);
        else passed++;
        serve_burst(LINE_B, 0, wd, rd, wr, early);
        checks++; if (i_line_resp !== 1'b1 || i_line_rdata !== LINE_B)
            $display("FAIL b2b_second: got resp=%b rdata=%h expected 1 and %h", i_line_resp, i_line_rdata, LINE_B);
        else passed++;
        i_line_read = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_unaligned();
        test_simultaneous(1);
        test_simultaneous(2);
        test_reset_mid_burst();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
